sm83_tcycle_seq: RTL and testbench

//   T-cycle/M-cycle sequencer for the SM83 core. Drives active-low one-hot phase strobes
//   t_n[] and an M-cycle counter straight into the core's NOR2 phase decoders.
//   An output is active only when both NOR inputs are low.

---
 rtl/sm83_tcycle_seq_if.sv | 25 ++
 rtl/sm83_tcycle_seq.sv | 119 +++++++++++
 tb/tb_sm83_tcycle_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sm83_tcycle_seq_if.sv
// Phase-sequencer bus: core-side control inputs and the registered phase outputs.
// master = core/controller side, slave = sm83_tcycle_seq.
interface sm83_tcycle_seq_if #(
  parameter int T_PER_M = 4,
  parameter int M_CNT_W = 3
);
  logic               halt_req;
  logic               wake;
  logic               mcyc_clr;
  logic               wait_n;
  logic [T_PER_M-1:0] t_n;
  logic [M_CNT_W-1:0] m_cnt;
  logic               m_end;
  logic               halted;

  modport master (
    output halt_req, wake, mcyc_clr, wait_n,
    input  t_n, m_cnt, m_end, halted
  );

  modport slave (
    input  halt_req, wake, mcyc_clr, wait_n,
    output t_n, m_cnt, m_end, halted
  );
endinterface

// File: rtl/sm83_tcycle_seq.sv
// SM83 T-cycle/M-cycle sequencer: active-low one-hot phase strobes, M-cycle counter, HALT.
// Optional memory wait stretching of WAIT_PHASE when SM83_TCYCLE_SEQ_WAIT_EN is defined.
module sm83_tcycle_seq #(
  parameter int T_PER_M    = 4,
  parameter int M_CNT_W    = 3,
  parameter int WAIT_PHASE = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  sm83_tcycle_seq_if.slave  bus
);

  localparam int P_W = (T_PER_M > 2) ? $clog2(T_PER_M) : 1;

  localparam logic [P_W-1:0]     P_LAST = P_W'(T_PER_M - 1);
  localparam logic [P_W-1:0]     P_ONE  = P_W'(1);
  localparam logic [M_CNT_W-1:0] M_ONE  = M_CNT_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]         state_q,  state_d;
  logic [P_W-1:0]     p_q,      p_d;
  logic [M_CNT_W-1:0] m_cnt_q,  m_cnt_d;
  logic [T_PER_M-1:0] t_n_q,    t_n_d;
  logic               m_end_q,  m_end_d;
  logic               halted_q, halted_d;
  logic               stall;

`ifdef SM83_TCYCLE_SEQ_WAIT_EN
  localparam logic [P_W-1:0] P_WAIT = P_W'(WAIT_PHASE);
  // Stretch holds the whole sequencer, including m_cnt, for as long as wait_n stays low.
  assign stall = (state_q == ST_RUN) && (p_q == P_WAIT) && !bus.wait_n;
`else
  logic unused_wait;
  assign unused_wait = bus.wait_n;
  assign stall       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_cnt_d = m_cnt_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
        p_d     = '0;
        m_cnt_d = '0;
      end
      ST_RUN: begin
        if (stall) begin
          p_d = p_q;
        end else if (p_q == P_LAST) begin
          // M-cycle boundary: the only place halt_req/wake/mcyc_clr are looked at.
          p_d = '0;
          if (bus.halt_req && !bus.wake) begin
            state_d = ST_HALT;
            m_cnt_d = '0;
          end else if (bus.mcyc_clr) begin
            m_cnt_d = '0;
          end else begin
            m_cnt_d = m_cnt_q + M_ONE;
          end
        end else begin
          p_d = p_q + P_ONE;
        end
      end
      ST_HALT: begin
        if (bus.wake) begin
          state_d = ST_RUN;
          p_d     = '0;
          m_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        p_d     = '0;
        m_cnt_d = '0;
      end
    endcase
  end

  // Strobes are decoded from next-state so every output leaves a flop directly.
  for (genvar i = 0; i < T_PER_M; i++) begin : g_tn
    assign t_n_d[i] = !((state_d == ST_RUN) && (p_d == P_W'(i)));
  end

  assign m_end_d  = (state_d == ST_RUN) && (p_d == P_LAST);
  assign halted_d = (state_d == ST_HALT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      p_q      <= '0;
      m_cnt_q  <= '0;
      t_n_q    <= '1;
      m_end_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      m_cnt_q  <= m_cnt_d;
      t_n_q    <= t_n_d;
      m_end_q  <= m_end_d;
      halted_q <= halted_d;
    end
  end

  assign bus.t_n    = t_n_q;
  assign bus.m_cnt  = m_cnt_q;
  assign bus.m_end  = m_end_q;
  assign bus.halted = halted_q;

  // Exactly one strobe low in RUN, none anywhere else.
  a_tn_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(~t_n_q) && ($onehot(~t_n_q) == (state_q == ST_RUN)));

endmodule

// File: tb/tb_sm83_tcycle_seq.sv
// Bench for sm83_tcycle_seq (T_PER_M=4, M_CNT_W=3): vector table through a scoreboard
// queue, then a hand-written asynchronous mid-cycle reset sequence.
module tb_sm83_tcycle_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sm83_tcycle_seq_if #(.T_PER_M(4), .M_CNT_W(3)) bus ();

  sm83_tcycle_seq #(.T_PER_M(4), .M_CNT_W(3), .WAIT_PHASE(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic       rst_n;
    logic       halt_req;
    logic       wake;
    logic       mcyc_clr;
    logic       wait_n;
    logic [3:0] t_n;
    logic [2:0] m_cnt;
    logic       m_end;
    logic       halted;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input logic r, h, w, c, wn, input logic [3:0] t,
                     input logic [2:0] m, input logic e, hl);
    vec_t v;
    v.rst_n = r; v.halt_req = h; v.wake = w; v.mcyc_clr = c; v.wait_n = wn;
    v.t_n = t; v.m_cnt = m; v.m_end = e; v.halted = hl;
    vecs.push_back(v);
  endtask

  // RUN-phase vector: expect strobe p low, m_end on the last phase.
  task automatic run(input int p, input int m, input logic h, w, c, wn);
    logic [3:0] t;
    t = 4'b0001 << p;
    add(1'b1, h, w, c, wn, ~t, 3'(m), (p == 3), 1'b0);
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got t_n=%b m_cnt=%0d m_end=%b halted=%b, want t_n=%b m_cnt=%0d m_end=%b halted=%b",
               name, got[8:5], got[4:2], got[1], got[0], exp[8:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [8:0] dut_out();
    return {bus.t_n, bus.m_cnt, bus.m_end, bus.halted};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    bus.halt_req = 1'b0; bus.wake = 1'b0; bus.mcyc_clr = 1'b0; bus.wait_n = 1'b1;

    // Reset held 3 clocks.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 3'd0, 1'b0, 1'b0);
    // Free run 9 M-cycles: m_cnt 0..7 then wraps to 0.
    for (int m = 0; m < 9; m++)
      for (int p = 0; p < 4; p++) run(p, m % 8, 1'b0, 1'b0, 1'b0, 1'b1);
    // Off-boundary mcyc_clr / halt_req are ignored.
    run(0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(2, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    run(3, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    // HALT at boundary clears m_cnt; 5 idle clocks with noise; wake restarts at T0.
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 3'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 3'd0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 3'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 3'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 3'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 3'd0, 1'b0, 1'b1);
    run(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int p = 1; p < 4; p++) run(p, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    // halt_req + wake: wake wins, normal increment.
    run(0, 1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int p = 1; p < 4; p++) run(p, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    // halt_req + wake + mcyc_clr: no halt, m_cnt cleared.
    run(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int p = 1; p < 4; p++) run(p, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int p = 1; p < 4; p++) run(p, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    // mcyc_clr + halt_req: HALTED with m_cnt 0, then wake.
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 3'd0, 1'b0, 1'b1);
    run(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    run(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(2, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    // wait_n low for 3 clocks while at phase 2.
`ifdef SM83_TCYCLE_SEQ_WAIT_EN
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 3'd0, 1'b0, 1'b0);
    run(3, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    run(3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    run(1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(2, 1, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset_n      = vecs[i].rst_n;
      bus.halt_req = vecs[i].halt_req;
      bus.wake     = vecs[i].wake;
      bus.mcyc_clr = vecs[i].mcyc_clr;
      bus.wait_n   = vecs[i].wait_n;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), dut_out(), {e.t_n, e.m_cnt, e.m_end, e.halted});
    end

    // Asynchronous reset in the middle of T2.
    #3;
    check("pre_reset_t2", dut_out(), {4'b1011, 3'd1, 1'b0, 1'b0});
    reset_n = 1'b0;
    #1;
    check("async_reset", dut_out(), {4'hF, 3'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("reset_held", dut_out(), {4'hF, 3'd0, 1'b0, 1'b0});
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("restart_t0", dut_out(), {4'b1110, 3'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("restart_t1", dut_out(), {4'b1101, 3'd0, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
